// File: rtl/ahb_sim_console_pkg.sv
// Shared definitions for the simulation console AHB-Lite responder.
package ahb_sim_console_pkg;

  // Register offsets, decoded from haddr[3:2]
  localparam logic [1:0] OFF_TXDATA   = 2'd0;
  localparam logic [1:0] OFF_STATUS   = 2'd1;
  localparam logic [1:0] OFF_TESTSTAT = 2'd2;
  localparam logic [1:0] OFF_RSVD     = 2'd3;

  // Active AHB transfer types
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // Response codes
  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Default test-status signatures
  localparam logic [31:0] PASS_CODE_DEF = 32'hCAFFE000;
  localparam logic [31:0] FAIL_CODE_DEF = 32'hDEADD000;

  // Data-phase FSM
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } state_t;

endpackage

// File: rtl/ahb_sim_console_fifo.sv
// Synchronous FIFO holding console bytes between the bus and the drain stream.
module sim_console_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage write; contents need no reset since empty masks the head
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ahb_sim_console.sv
// AHB-Lite console/test-status responder: TX FIFO drained at a bounded rate,
// plus a sticky pass/fail signature register.
module ahb_sim_console
  import ahb_sim_console_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DRAIN_DIV  = 4,
  parameter logic [31:0] PASS_CODE  = PASS_CODE_DEF,
  parameter logic [31:0] FAIL_CODE  = FAIL_CODE_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hreadyout,
  output logic        hresp,
  output logic [31:0] hrdata,
  output logic        char_valid,
  output logic [7:0]  char_data,
  input  logic        char_ready,
  output logic        test_done,
  output logic        test_pass
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned GW = (DRAIN_DIV > 1) ? $clog2(DRAIN_DIV) : 1;

  state_t        state_q, state_d;
  logic [1:0]    dp_off;
  logic          dp_write;
  logic [2:0]    dp_size;
  logic [7:0]    wdata_hold;
  logic [31:0]   teststat_q;
  logic          done_q, pass_q;
  logic [GW-1:0] gap_q;

  logic          addr_ok, phase_end, take, tx_wr, ts_wr;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_din, fifo_dout;
  logic [CW-1:0] fifo_count;

  logic          unused_bits;
  assign unused_bits = ^{haddr[31:4], haddr[1:0], dp_size, FAIL_CODE};

  assign addr_ok = hsel && hready && ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));
  assign tx_wr   = dp_write && (dp_off == OFF_TXDATA);
  assign take    = phase_end && addr_ok;

  sim_console_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Data-phase FSM: response signalling, FIFO push and next-phase acceptance
  always_comb begin
    state_d   = state_q;
    hreadyout = 1'b1;
    hresp     = HRESP_OKAY;
    fifo_push = 1'b0;
    fifo_din  = hwdata[7:0];
    phase_end = 1'b0;
    ts_wr     = 1'b0;
    case (state_q)
      ST_IDLE: phase_end = 1'b1;
      ST_DATA: begin
        if (tx_wr && fifo_full) begin
          hreadyout = 1'b0;
          state_d   = ST_WAIT;
        end else begin
          phase_end = 1'b1;
          fifo_push = tx_wr;
          ts_wr     = dp_write && (dp_off == OFF_TESTSTAT);
        end
      end
      ST_WAIT: begin
        fifo_din = wdata_hold;
        if (fifo_full) begin
          hreadyout = 1'b0;
        end else begin
          fifo_push = 1'b1;
          phase_end = 1'b1;
        end
      end
      ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = HRESP_ERROR;
        state_d   = ST_ERR2;
      end
      ST_ERR2: begin
        hresp     = HRESP_ERROR;
        phase_end = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    // Completing phase hands over to the next pipelined address phase, if any
    if (phase_end) begin
      if (addr_ok) state_d = (haddr[3:2] == OFF_RSVD) ? ST_ERR1 : ST_DATA;
      else         state_d = ST_IDLE;
    end
  end

  // Read mux, only live during a read data phase
  always_comb begin
    hrdata = '0;
    if ((state_q == ST_DATA) && !dp_write) begin
      case (dp_off)
        OFF_STATUS:   hrdata = {16'(fifo_count), 14'b0, fifo_empty, fifo_full};
        OFF_TESTSTAT: hrdata = teststat_q;
        default:      hrdata = '0;
      endcase
    end
  end

  // State, data-phase registers and test-status latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      dp_off     <= '0;
      dp_write   <= 1'b0;
      dp_size    <= '0;
      wdata_hold <= '0;
      teststat_q <= '0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (take) begin
        dp_off   <= haddr[3:2];
        dp_write <= hwrite;
        dp_size  <= hsize;
      end
      // hwdata is only guaranteed on the first data-phase cycle; keep it for a stall
      if (state_q == ST_DATA) wdata_hold <= hwdata[7:0];
      if (ts_wr) begin
        teststat_q <= hwdata;
        done_q     <= 1'b1;
        pass_q     <= (hwdata == PASS_CODE);
      end
    end
  end

  assign char_valid = !fifo_empty && (gap_q == '0);
  assign char_data  = fifo_empty ? 8'h00 : fifo_dout;
  assign fifo_pop   = char_valid && char_ready;
  assign test_done  = done_q;
  assign test_pass  = pass_q;

  // Drain pacing: reload on each handshake, count down and hold at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_q <= '0;
    end else if (fifo_pop) begin
      gap_q <= GW'(DRAIN_DIV - 1);
    end else if (gap_q != '0) begin
      gap_q <= gap_q - GW'(1);
    end
  end

endmodule

// File: tb/tb_ahb_sim_console.sv
// Directed self-checking bench for ahb_sim_console.
module tb_ahb_sim_console;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hsel = 1'b0;
  logic [31:0] haddr = '0;
  logic [1:0]  htrans = 2'b00;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'd2;
  logic [31:0] hwdata = '0;
  logic        hready;
  logic        hreadyout, hresp;
  logic [31:0] hrdata;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        char_ready = 1'b0;
  logic        test_done, test_pass;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [7:0] q_data[$];
  int         q_cyc[$];

  assign hready = hreadyout;

  ahb_sim_console #(
    .FIFO_DEPTH (16),
    .DRAIN_DIV  (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .hsel       (hsel),
    .haddr      (haddr),
    .htrans     (htrans),
    .hwrite     (hwrite),
    .hsize      (hsize),
    .hwdata     (hwdata),
    .hready     (hready),
    .hreadyout  (hreadyout),
    .hresp      (hresp),
    .hrdata     (hrdata),
    .char_valid (char_valid),
    .char_data  (char_data),
    .char_ready (char_ready),
    .test_done  (test_done),
    .test_pass  (test_pass)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Sink: record each handshake mid-cycle
  always @(negedge clk) begin
    if (rst_n && char_valid && char_ready) begin
      q_data.push_back(char_data);
      q_cyc.push_back(cyc);
    end
  end

  task automatic bus_idle();
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
  endtask

  task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data, output int waits);
    hsel = 1'b1; haddr = addr; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
    @(posedge clk); #1;
    bus_idle();
    hwdata = data;
    waits = 0;
    while (hreadyout !== 1'b1 && waits < 500) begin
      @(posedge clk); #1;
      waits++;
      hwdata = ~data;
    end
    @(posedge clk); #1;
  endtask

  task automatic ahb_read(input logic [31:0] addr, output logic [31:0] rdata,
                          output logic resp, output logic first_resp, output int waits);
    hsel = 1'b1; haddr = addr; htrans = 2'b10; hwrite = 1'b0; hsize = 3'd2;
    @(posedge clk); #1;
    bus_idle();
    first_resp = hresp;
    waits = 0;
    while (hreadyout !== 1'b1 && waits < 500) begin
      @(posedge clk); #1;
      waits++;
    end
    rdata = hrdata;
    resp  = hresp;
    @(posedge clk); #1;
  endtask

  task automatic wait_chars(input int n, input int budget);
    int k = 0;
    while (q_data.size() < n && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    checks++;
    if (q_data.size() < n) begin
      $display("FAIL wait_chars got=%0d want=%0d", q_data.size(), n);
      failures++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus_idle();
    char_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    q_data.delete();
    q_cyc.delete();
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic rs, fr; int w;
    do_reset();
    checks++; if (hreadyout !== 1'b1) begin $display("FAIL rst_hreadyout got=%b want=1", hreadyout); failures++; end
    checks++; if (hresp !== 1'b0) begin $display("FAIL rst_hresp got=%b want=0", hresp); failures++; end
    checks++; if (hrdata !== 32'h0) begin $display("FAIL rst_hrdata got=%h want=0", hrdata); failures++; end
    checks++; if (char_valid !== 1'b0) begin $display("FAIL rst_char_valid got=%b want=0", char_valid); failures++; end
    checks++; if (char_data !== 8'h00) begin $display("FAIL rst_char_data got=%h want=00", char_data); failures++; end
    checks++; if (test_done !== 1'b0 || test_pass !== 1'b0) begin
      $display("FAIL rst_test got=%b%b want=00", test_done, test_pass); failures++; end
    ahb_read(32'h4, rd, rs, fr, w);
    checks++; if (rd !== 32'h0000_0002) begin $display("FAIL rst_status got=%h want=00000002", rd); failures++; end
  endtask

  task automatic test_drain_rate();
    int w1, w2;
    char_ready = 1'b1;
    q_data.delete(); q_cyc.delete();
    ahb_write(32'h0, 32'h0000_0041, w1);
    ahb_write(32'h0, 32'h0000_0042, w2);
    wait_chars(2, 100);
    checks++; if (w1 != 0 || w2 != 0) begin $display("FAIL drain_waits got=%0d,%0d want=0,0", w1, w2); failures++; end
    if (q_data.size() >= 2) begin
      checks++; if (q_data[0] !== 8'h41) begin $display("FAIL drain_byte0 got=%h want=41", q_data[0]); failures++; end
      checks++; if (q_data[1] !== 8'h42) begin $display("FAIL drain_byte1 got=%h want=42", q_data[1]); failures++; end
      checks++; if (q_cyc[1] - q_cyc[0] != 4) begin
        $display("FAIL drain_gap got=%0d want=4", q_cyc[1] - q_cyc[0]); failures++; end
    end
  endtask

  task automatic test_full_stall();
    logic [31:0] rd; logic rs, fr; int w, wmax, w17;
    char_ready = 1'b0;
    q_data.delete(); q_cyc.delete();
    wmax = 0;
    for (int i = 0; i < 16; i++) begin
      ahb_write(32'h0, 32'h60 + i, w);
      if (w > wmax) wmax = w;
    end
    checks++; if (wmax != 0) begin $display("FAIL fill_waits got=%0d want=0", wmax); failures++; end
    ahb_read(32'h4, rd, rs, fr, w);
    checks++; if (rd !== 32'h0010_0001) begin $display("FAIL full_status got=%h want=00100001", rd); failures++; end
    fork
      ahb_write(32'h0, 32'h0000_0070, w17);
      begin repeat (5) @(posedge clk); #1 char_ready = 1'b1; end
    join
    checks++; if (w17 != 5) begin $display("FAIL stall_waits got=%0d want=5", w17); failures++; end
    wait_chars(17, 300);
    for (int i = 0; i < 17; i++) begin
      if (i < q_data.size()) begin
        checks++;
        if (q_data[i] !== ((i < 16) ? 8'(8'h60 + i) : 8'h70)) begin
          $display("FAIL stall_order[%0d] got=%h want=%h", i, q_data[i], (i < 16) ? 8'(8'h60 + i) : 8'h70);
          failures++;
        end
      end
    end
  endtask

  task automatic test_error();
    logic [31:0] rd; logic rs, fr; int w;
    ahb_read(32'hC, rd, rs, fr, w);
    checks++; if (w != 1) begin $display("FAIL err_waits got=%0d want=1", w); failures++; end
    checks++; if (fr !== 1'b1) begin $display("FAIL err1_hresp got=%b want=1", fr); failures++; end
    checks++; if (rs !== 1'b1) begin $display("FAIL err2_hresp got=%b want=1", rs); failures++; end
    ahb_read(32'h4, rd, rs, fr, w);
    checks++; if (rs !== 1'b0 || w != 0) begin $display("FAIL post_err_okay got=%b/%0d want=0/0", rs, w); failures++; end
    checks++; if (rd !== 32'h0000_0002) begin $display("FAIL post_err_status got=%h want=00000002", rd); failures++; end
  endtask

  task automatic test_teststat();
    logic [31:0] rd; logic rs, fr; int w;
    ahb_write(32'h8, 32'hCAFFE000, w);
    checks++; if (test_done !== 1'b1 || test_pass !== 1'b1) begin
      $display("FAIL pass_flags got=%b%b want=11", test_done, test_pass); failures++; end
    ahb_read(32'h8, rd, rs, fr, w);
    checks++; if (rd !== 32'hCAFFE000) begin $display("FAIL pass_readback got=%h want=caffe000", rd); failures++; end
    ahb_write(32'h8, 32'hDEADD000, w);
    checks++; if (test_done !== 1'b1 || test_pass !== 1'b0) begin
      $display("FAIL fail_flags got=%b%b want=10", test_done, test_pass); failures++; end
    ahb_read(32'h8, rd, rs, fr, w);
    checks++; if (rd !== 32'hDEADD000) begin $display("FAIL fail_readback got=%h want=deadd000", rd); failures++; end
  endtask

  task automatic test_back_to_back();
    char_ready = 1'b0;
    q_data.delete(); q_cyc.delete();
    hsel = 1'b1; haddr = 32'h0; htrans = 2'b10; hwrite = 1'b1;
    @(posedge clk); #1;
    checks++; if (hreadyout !== 1'b1) begin $display("FAIL b2b_ready0 got=%b want=1", hreadyout); failures++; end
    haddr = 32'h0; hwdata = 32'h51;
    @(posedge clk); #1;
    checks++; if (hreadyout !== 1'b1) begin $display("FAIL b2b_ready1 got=%b want=1", hreadyout); failures++; end
    haddr = 32'h4; hwrite = 1'b0; hwdata = 32'h52;
    @(posedge clk); #1;
    bus_idle();
    checks++; if (hreadyout !== 1'b1 || hresp !== 1'b0) begin
      $display("FAIL b2b_ready2 got=%b%b want=10", hreadyout, hresp); failures++; end
    checks++; if (hrdata !== 32'h0002_0000) begin $display("FAIL b2b_status got=%h want=00020000", hrdata); failures++; end
    @(posedge clk); #1;
    char_ready = 1'b1;
    wait_chars(2, 100);
    if (q_data.size() >= 2) begin
      checks++; if (q_data[0] !== 8'h51 || q_data[1] !== 8'h52) begin
        $display("FAIL b2b_bytes got=%h%h want=5152", q_data[0], q_data[1]); failures++; end
    end
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] rd; logic rs, fr; int w;
    char_ready = 1'b0;
    for (int i = 0; i < 16; i++) ahb_write(32'h0, 32'h80 + i, w);
    hsel = 1'b1; haddr = 32'h0; htrans = 2'b10; hwrite = 1'b1;
    @(posedge clk); #1;
    bus_idle();
    hwdata = 32'hEE;
    checks++; if (hreadyout !== 1'b0) begin $display("FAIL wait_ready_c1 got=%b want=0", hreadyout); failures++; end
    @(posedge clk); #1;
    checks++; if (hreadyout !== 1'b0) begin $display("FAIL wait_ready_c2 got=%b want=0", hreadyout); failures++; end
    rst_n = 1'b0;
    #2;
    checks++; if (hreadyout !== 1'b1 || char_valid !== 1'b0) begin
      $display("FAIL rstwait_out got=%b%b want=10", hreadyout, char_valid); failures++; end
    checks++; if (test_done !== 1'b0) begin $display("FAIL rstwait_done got=%b want=0", test_done); failures++; end
    @(posedge clk); #1 rst_n = 1'b1;
    q_data.delete(); q_cyc.delete();
    ahb_read(32'h4, rd, rs, fr, w);
    checks++; if (rd !== 32'h0000_0002) begin $display("FAIL rstwait_status got=%h want=00000002", rd); failures++; end
    char_ready = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    checks++; if (q_data.size() != 0) begin $display("FAIL rstwait_emitted got=%0d want=0", q_data.size()); failures++; end
  endtask

  initial begin
    test_reset();
    test_drain_rate();
    test_full_stall();
    test_error();
    test_teststat();
    test_back_to_back();
    test_reset_in_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ahb_sim_console.md
Name: ahb_sim_console

Overview:
AHB-Lite responder for the nanorv32 data bus that accepts console characters and test-status words from the CPU. Firmware writes bytes to a TX register; they are buffered in a FIFO and drained to a char_valid/char_ready stream at a bounded rate, where a bench sink or host printer consumes them. A test-status register latches the pass/fail signature, so the bench sees completion through a decoded test_done/test_pass pair.

Parameters:
FIFO_DEPTH, 16, TX FIFO entries; power of 2, minimum 2.
DRAIN_DIV, 4, minimum clk cycles between successive char_valid handshakes; minimum 1.
PASS_CODE, 32'hCAFFE000, TESTSTAT value meaning pass.
FAIL_CODE, 32'hDEADD000, TESTSTAT value meaning explicit fail.

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
hsel  in  1  slave select
haddr  in  32  address; only [3:2] decoded, [1:0] ignored
htrans  in  2  AHB transfer type; NONSEQ=2'b10, SEQ=2'b11 are active
hwrite  in  1  1 = write
hsize  in  3  transfer size
hwdata  in  32  write data, valid in data phase
hready  in  1  bus-level ready; address phase is sampled only when high
hreadyout  out  1  slave ready
hresp  out  1  0 = OKAY, 1 = ERROR
hrdata  out  32  read data
char_valid  out  1  console byte available
char_data  out  8  console byte
char_ready  in  1  sink accepts byte
test_done  out  1  sticky; TESTSTAT has been written
test_pass  out  1  sticky; last TESTSTAT write equalled PASS_CODE

Behaviour:
- Address phase is accepted when hsel & hready & htrans[1]; latch offset, hwrite and hsize into data-phase registers.
- Register map (offset = haddr[3:2]):
  - 0 TXDATA: W pushes hwdata[7:0]; R returns 0.
  - 1 STATUS: R = {count[15:0], 14'b0, empty, full}; W ignored, OKAY.
  - 2 TESTSTAT: W latches the full word; R returns the last value written.
  - 3: reserved; any access gives ERROR.
- Data-phase FSM states: IDLE, DATA, WAIT, ERR1, ERR2.
  - IDLE: on accepted address phase, go to DATA, or to ERR1 if offset is 3.
  - DATA: zero-wait-state completion, hreadyout=1, hresp=0. If another phase is accepted in the same cycle, stay pipelined (back-to-back transfers are supported).
  - TXDATA write while FIFO full: go to WAIT with hreadyout=0. The push occurs on the first cycle the FIFO is not full, with hreadyout=1 in that cycle. The hwdata value is captured on the first data-phase cycle and held.
  - ERR1: hreadyout=0, hresp=1. ERR2: hreadyout=1, hresp=1. A reserved-offset write has no side effect.
- Reads: hrdata is driven combinationally from the data-phase offset during the data phase, and is 0 otherwise.
- hsize: any size is accepted; TXDATA always takes byte lane [7:0], with no lane steering.
- FIFO:
  - Simultaneous push and pop is legal and leaves count unchanged.
  - A push when full is impossible (guarded by WAIT).
  - Pointers wrap modulo FIFO_DEPTH; count is 0..FIFO_DEPTH.
  - full = (count==FIFO_DEPTH); empty = (count==0).
  - STATUS reflects count at the data-phase cycle, before that cycle's push or pop.
- Drain:
  - char_valid = !empty & (gap_cnt==0); char_data = FIFO head.
  - Handshake when char_valid & char_ready: pop, and load gap_cnt = DRAIN_DIV-1.
  - gap_cnt decrements to 0 and saturates there.
  - char_data is stable while char_valid is high and char_ready is low.
- Test status: a TESTSTAT write sets test_done=1 and test_pass=(hwdata==PASS_CODE). Any other value, FAIL_CODE included, gives pass=0. A later write overrides pass.
- Reset values: hreadyout=1, hresp=0, hrdata=0, char_valid=0, char_data=0, test_done=0, test_pass=0, FIFO empty, gap_cnt=0, TESTSTAT=0, FSM IDLE. Reset mid-transfer discards the pending phase and FIFO contents.

Decomposition:
- Shared package: offsets (TXDATA/STATUS/TESTSTAT/RSVD), HTRANS encodings, HRESP codes, PASS_CODE/FAIL_CODE defaults, FSM state encoding.
- One sub-module: sim_console_fifo (sync FIFO with push/pop/full/empty/count, parameterised by depth and width).

Test Plan:
1. Write 0x41, 0x42 to TXDATA with char_ready=1, DRAIN_DIV=4 -> char_data 0x41 then 0x42, handshakes exactly 4 cycles apart, both writes zero-wait.
2. char_ready=0, 17 writes with FIFO_DEPTH=16 -> STATUS reads count=16 and full=1; 17th write holds hreadyout=0; raising char_ready completes it, with 17 bytes delivered in order.
3. Read offset 3 -> ERR1 (hreadyout=0, hresp=1) then ERR2 (hreadyout=1, hresp=1); a following STATUS read returns OKAY.
4. Write 0xCAFFE000 to TESTSTAT -> test_done=1, test_pass=1, readback 0xCAFFE000; then write 0xDEADD000 -> test_pass=0, test_done stays 1.
5. Back-to-back NONSEQ writes TXDATA, TXDATA, then read STATUS with char_ready=0 -> STATUS count=2, no wait states.
6. Assert rst_n low during WAIT with 16 bytes queued -> hreadyout=1, char_valid=0, count=0 on release; the stalled byte is never emitted.
